// File: rtl/selector_block_b.sv
// selector_block_b: serial frame receiver for the selector-block link.
// Rebuilds LSB-first words from strobed start/data/parity/stop frames.
module selector_block_b #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             din,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic [3:0]       frame_cnt,
  output logic             busy
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_bit;
  logic             par_ok;

  assign last_bit = (bitcnt_q == BW'(WIDTH - 1));

  // Good frame: parity bit is 1 exactly when the data holds an even number of ones.
  assign par_ok = !PARITY_EN || (par_q == ~(^shift_q));

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    if (enable) begin
      unique case (state_q)
        S_IDLE: begin
          if (!din) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d[bitcnt_q] = din;
          bitcnt_d = bitcnt_q + BW'(1);
          if (last_bit) begin
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          par_d   = din;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (!din) begin
            state_d = S_ERR;
            ferr_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            if (par_ok) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              cnt_d   = cnt_q + 4'd1;
            end else begin
              perr_d = 1'b1;
            end
          end
        end
        S_ERR: begin
          if (din) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign frame_cnt  = cnt_q;
  assign busy       = (state_q != S_IDLE);

endmodule
